pwm_cfg_commit: RTL

Shadow-register commit controller between the SPI register-write path and the PWM output datapath. It accepts decoded register writes (address 0–4) into shadow registers and tracks which ones are dirty. It applies all pending writes atomically to the active configuration only at a PWM period boundary, or on an explicit request. It owns the PWM period timer (prescaler plus 8-bit ramp) so that commit timing and the PWM count share one time base.

---
 rtl/pwm_cfg_pkg.sv | 17 +
 rtl/pwm_period_timer.sv | 31 +++
 rtl/pwm_cfg_commit.sv | 87 ++++++++
 3 files changed

// File: rtl/pwm_cfg_pkg.sv
// Shared constants and FSM encoding for the PWM shadow-register commit controller.
package pwm_cfg_pkg;

  localparam int NUM_REGS = 5;

  localparam logic [6:0] ADDR_OUT_LO = 7'd0;
  localparam logic [6:0] ADDR_OUT_HI = 7'd1;
  localparam logic [6:0] ADDR_PWM_LO = 7'd2;
  localparam logic [6:0] ADDR_PWM_HI = 7'd3;
  localparam logic [6:0] ADDR_DUTY   = 7'd4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_PENDING = 2'd1;
  localparam state_t ST_COMMIT  = 2'd2;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM time base: prescaler feeding an 8-bit ramp, flags the last clk of each period.
module pwm_period_timer #(
  parameter int PRESCALE = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] pwm_cnt,
  output logic       period_end
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] pre_cnt;
  logic          pre_wrap;

  assign pre_wrap   = (pre_cnt == PW'(PRESCALE - 1));
  assign period_end = pre_wrap & (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (pre_wrap) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/pwm_cfg_commit.sv
// Shadow/dirty register file with an atomic commit to the active PWM configuration,
// committed at a period boundary or on request, never while the host transaction holds.
module pwm_cfg_commit
  import pwm_cfg_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  input  logic [6:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  input  logic        hold,
  input  logic        commit_now,
  output logic        err_addr,
  output logic [15:0] en_reg_out,
  output logic [15:0] en_reg_pwm,
  output logic [7:0]  pwm_duty_cycle,
  output logic [7:0]  pwm_cnt,
  output logic        period_end,
  output logic        pending
);

  logic [NUM_REGS-1:0][7:0] shadow;
  logic [NUM_REGS-1:0][7:0] active;
  logic [NUM_REGS-1:0]      dirty;
  state_t                   state, state_nxt;
  logic                     wr_fire, in_range, wr_hit;

  pwm_period_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_cnt    (pwm_cnt),
    .period_end (period_end)
  );

  assign wr_ready = (state != ST_COMMIT);
  assign wr_fire  = wr_valid & wr_ready;
  assign in_range = (wr_addr < 7'(NUM_REGS));
  assign wr_hit   = wr_fire & in_range;
  assign pending  = |dirty;

  assign en_reg_out     = {active[ADDR_OUT_HI], active[ADDR_OUT_LO]};
  assign en_reg_pwm     = {active[ADDR_PWM_HI], active[ADDR_PWM_LO]};
  assign pwm_duty_cycle = active[ADDR_DUTY];

  // Writes are blocked during COMMIT, so the copy and the shadow update never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      dirty  <= '0;
      active <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (state == ST_COMMIT) begin
          if (dirty[i]) active[i] <= shadow[i];
          dirty[i] <= 1'b0;
        end else if (wr_hit && (wr_addr == 7'(i))) begin
          shadow[i] <= wr_data;
          dirty[i]  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_addr <= 1'b0;
    else        err_addr <= wr_fire & ~in_range;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (wr_hit) state_nxt = ST_PENDING;
      ST_PENDING: if ((period_end | commit_now) & ~hold) state_nxt = ST_COMMIT;
      ST_COMMIT:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

endmodule
